// File: rtl/conf_editor.sv
// Front-panel edit sequencer for the Morse timing config block; any button acts 1 ce-cycle after it is sampled.
// No backpressure: buttons are dropped while busy. A commit then holds until the SETTLE countdown ends and conf_ready is seen.
`ifndef UNIT_BCD_W
`define UNIT_BCD_W 6
`endif

module conf_editor #(
    parameter int NUM_PARAMS    = 5,
    parameter int DIGITS        = `UNIT_BCD_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  btn_next,
    input  logic                  btn_enter,
    input  logic                  btn_cancel,
    input  logic                  btn_inc,
    input  logic                  btn_dec,
    input  logic                  btn_digit,
    input  logic                  conf_ready,
    input  logic [DIGITS*4-1:0]   selected_value,
    output logic [2:0]            selected_index,
    output logic [DIGITS*4-1:0]   selected_new_value,
    output logic                  selected_set,
    output logic [DIGITS*4-1:0]   display_value,
    output logic [2:0]            cursor,
    output logic                  editing,
    output logic                  busy,
    output logic                  err
);

    localparam int W = DIGITS * 4;

    typedef enum logic [2:0] {
        S_BROWSE = 3'd0,
        S_EDIT   = 3'd1,
        S_COMMIT = 3'd2,
        S_SETTLE = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t         state, state_n;
    logic [2:0]     index_n, cursor_n;
    logic [W-1:0]   edit_buf, edit_buf_n;
    logic [7:0]     settle_cnt, settle_cnt_n;
    logic           set_n, err_n;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_BROWSE;
            selected_index <= '0;
            cursor         <= '0;
            edit_buf       <= '0;
            settle_cnt     <= '0;
            selected_set   <= 1'b0;
            err            <= 1'b0;
            editing        <= 1'b0;
            busy           <= 1'b0;
        end else if (ce) begin
            state          <= state_n;
            selected_index <= index_n;
            cursor         <= cursor_n;
            edit_buf       <= edit_buf_n;
            settle_cnt     <= settle_cnt_n;
            selected_set   <= set_n;
            err            <= err_n;
            editing        <= (state_n == S_EDIT);
            busy           <= (state_n == S_COMMIT) || (state_n == S_SETTLE) ||
                              (state_n == S_WAIT);
        end
    end

    // Each state only looks at its own meaningful buttons, highest priority first.
    always_comb begin
        state_n      = state;
        index_n      = selected_index;
        cursor_n     = cursor;
        edit_buf_n   = edit_buf;
        settle_cnt_n = settle_cnt;
        set_n        = 1'b0;
        err_n        = 1'b0;
        case (state)
            S_BROWSE: begin
                if (btn_enter) begin
                    edit_buf_n = selected_value;
                    cursor_n   = '0;
                    state_n    = S_EDIT;
                end else if (btn_next) begin
                    index_n = (selected_index == 3'(NUM_PARAMS - 1)) ? 3'd0
                                                                     : selected_index + 3'd1;
                end
            end
            S_EDIT: begin
                if (btn_cancel) begin
                    edit_buf_n = '0;
                    state_n    = S_BROWSE;
                end else if (btn_enter) begin
                    if (edit_buf == '0) begin
                        err_n = 1'b1;
                    end else begin
                        set_n   = 1'b1;
                        state_n = S_COMMIT;
                    end
                end else if (btn_inc) begin
                    for (int d = 0; d < DIGITS; d++) begin
                        if (cursor == 3'(d)) edit_buf_n[d*4 +: 4] = bcd_inc(edit_buf[d*4 +: 4]);
                    end
                end else if (btn_dec) begin
                    for (int d = 0; d < DIGITS; d++) begin
                        if (cursor == 3'(d)) edit_buf_n[d*4 +: 4] = bcd_dec(edit_buf[d*4 +: 4]);
                    end
                end else if (btn_digit) begin
                    cursor_n = (cursor == 3'(DIGITS - 1)) ? 3'd0 : cursor + 3'd1;
                end
            end
            S_COMMIT: begin
                settle_cnt_n = 8'(SETTLE_CYCLES);
                state_n      = S_SETTLE;
            end
            S_SETTLE: begin
                // Leaving on the count of 1 makes WAIT the SETTLE_CYCLES-th cycle after SETTLE begins.
                if (settle_cnt <= 8'd1) begin
                    settle_cnt_n = '0;
                    state_n      = S_WAIT;
                end else begin
                    settle_cnt_n = settle_cnt - 8'd1;
                end
            end
            S_WAIT: begin
                if (conf_ready) state_n = S_BROWSE;
            end
            default: state_n = S_BROWSE;
        endcase
    end

    assign selected_new_value = edit_buf;
    assign display_value      = (state == S_EDIT) ? edit_buf : selected_value;

endmodule

// File: doc/conf_editor.md
# conf_editor

Front-panel controller that sequences edits to the Morse timing configuration block. Debounced button pulses browse the five configuration parameters, edit the selected one digit-by-digit in BCD, and commit it through the configuration block's select/set port. After a commit it waits for the timing recompute to finish (`ready`) before accepting further input. It sits between the button-debounce layer and the configuration block.

## Interface
- `NUM_PARAMS`, 5, number of selectable parameters; index wraps `NUM_PARAMS-1` -> 0.
- `DIGITS`, `` `UNIT_BCD_W ``, BCD digits per value; the value width is `DIGITS*4`.
- `SETTLE_CYCLES`, 2, ce-qualified cycles to wait after `selected_set` before sampling `conf_ready`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable; all state advances only when `ce=1`.
- `btn_next`  in  1  one-cycle pulse: select the next parameter.
- `btn_enter`  in  1  one-cycle pulse: start an edit, or commit the current edit.
- `btn_cancel`  in  1  one-cycle pulse: abandon the current edit.
- `btn_inc`  in  1  one-cycle pulse: increment the digit at the cursor.
- `btn_dec`  in  1  one-cycle pulse: decrement the digit at the cursor.
- `btn_digit`  in  1  one-cycle pulse: move the cursor one digit more significant.
- `conf_ready`  in  1  `ready` output of the configuration block.
- `selected_value`  in  `DIGITS*4`  current value of the selected parameter.
- `selected_index`  out  3  parameter index driven to the configuration block.
- `selected_new_value`  out  `DIGITS*4`  edit buffer.
- `selected_set`  out  1  commit strobe.
- `display_value`  out  `DIGITS*4`  the edit buffer while editing, otherwise `selected_value`.
- `cursor`  out  3  active digit, 0 = least significant.
- `editing`  out  1  high in EDIT.
- `busy`  out  1  high in COMMIT, SETTLE and WAIT.
- `err`  out  1  one-cycle pulse when a commit is rejected.

## Operation
State machine: BROWSE, EDIT, COMMIT, SETTLE, WAIT.

**Button priority.** When several buttons pulse in the same ce-cycle, exactly one is acted on: `btn_cancel` > `btn_enter` > `btn_inc` > `btn_dec` > `btn_digit` > `btn_next`. Buttons that are not meaningful in the current state are ignored.

**BROWSE**
- `btn_next`: `selected_index` += 1, wrapping from `NUM_PARAMS-1` to 0.
- `btn_enter`: load the edit buffer from `selected_value`, set `cursor` to 0, go to EDIT.

**EDIT**
- `btn_inc`: digit at the cursor goes 0..8 -> +1; 9 or any non-BCD nibble (A–F) -> 0. No carry into the next digit.
- `btn_dec`: digit at the cursor goes 1..9 -> -1; 0 or any non-BCD nibble -> 9. No borrow.
- `btn_digit`: `cursor` += 1, wrapping from `DIGITS-1` to 0.
- `btn_cancel`: discard the buffer, go to BROWSE.
- `btn_enter` with a buffer equal to all zeros: pulse `err` for one cycle and stay in EDIT; the buffer is unchanged.
- `btn_enter` with a nonzero buffer: go to COMMIT.

**COMMIT**
- `selected_set` is 1 for exactly one ce-cycle, with `selected_new_value` = buffer and `selected_index` stable.
- Then load the settle counter with `SETTLE_CYCLES` and go to SETTLE.

**SETTLE**
- Decrement the counter each ce-cycle; at 0 go to WAIT.

**WAIT**
- When `conf_ready=1`, go to BROWSE.

**Locked inputs**
- `selected_index` and `selected_new_value` never change while `busy=1`.
- All buttons are ignored while `busy=1`.

**Reset values** (`rst=1`, synchronous, overrides `ce`):
- state = BROWSE
- `selected_index` = 0, `cursor` = 0, edit buffer = 0
- `selected_set` = 0, `err` = 0, `editing` = 0, `busy` = 0
- settle counter = 0

Reset in the middle of an edit or a commit aborts it. No second `selected_set` is issued after reset.

## Timing
- All outputs are registered except `display_value`, which is a combinational mux.
- Button to effect: a button sampled on ce-cycle N updates state and outputs visible in cycle N+1.
- Commit sequence, counted in ce-cycles after the committing `btn_enter`:
  - +1: `selected_set` high.
  - +2: `selected_set` low; SETTLE begins.
  - From `SETTLE_CYCLES` cycles later: `conf_ready` is sampled.
- Minimum commit-to-BROWSE latency is `3+SETTLE_CYCLES` ce-cycles.
- `ce=0`: all registers hold. A registered `selected_set` stays high across ce-low cycles. This is correct because the configuration block also qualifies `selected_set` with `ce`.
- `err`: high for one ce-cycle, then cleared. It also holds across ce-low cycles.

## Test plan
- **Reset, browse and wrap:** apply reset, then 5× `btn_next`. Required: `selected_index` steps 1,2,3,4,0; `selected_set` stays 0.
- **Edit and commit:** index 0, `selected_value` = 0x001000; enter, inc, inc, enter. Required: one `selected_set` pulse with `selected_new_value` = 0x001002 and index 0; `busy` high until `conf_ready` = 1 (checked after the settle period); then `editing` = 0.
- **Digit wrap:** with 0x000009, inc at cursor 0 gives 0x000000. Dec at cursor 0 then gives 0x000009. Moving the cursor 6× with `btn_digit` returns it to 0 (`DIGITS` = 6).
- **Zero rejection:** buffer 0x000000 and `btn_enter`. Required: `err` pulses once, no `selected_set`, state stays EDIT.
- **Simultaneous buttons and cancel:** `btn_cancel` and `btn_enter` in the same cycle. Required: return to BROWSE with no `selected_set`. Buttons pulsed during WAIT: no effect.
- **ce gating and reset mid-commit:** hold `ce=0` for 3 cycles during COMMIT. Required: `selected_set` held, state unchanged. Assert `rst` in SETTLE. Required: BROWSE, index 0, `busy` = 0 on the next cycle.
